// File: rtl/complement.sv
// Registered two's/one's complement unit with overflow and zero flags, one-cycle latency.
// Optional macro COMPLEMENT_SATURATE_EN: negating the most-negative value saturates to most-positive.
module complement #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] iin,
    input  logic             enable,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero
);

    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef COMPLEMENT_SATURATE_EN
    localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    // Negation of the most-negative value has no representable result: wrap or clamp.
    function automatic logic signed [WIDTH-1:0] sat_negate(input logic signed [WIDTH-1:0] a);
`ifdef COMPLEMENT_SATURATE_EN
        if (a == MOST_NEG)
            return MOST_POS;
        else
            return -a;
`else
        return -a;
`endif
    endfunction

    function automatic logic negate_ovf(input logic signed [WIDTH-1:0] a, input logic m);
        return (!m) && (a == MOST_NEG);
    endfunction

    logic signed [WIDTH-1:0] w_iin_p0;
    logic signed [WIDTH-1:0] w_result_p0;
    logic                    w_ovf_p0;

    logic signed [WIDTH-1:0] r_out_p1;
    logic                    r_vld_p1;
    logic                    r_ovf_p1;
    logic                    r_zero_p1;

    // Stage p0: combinational complement of the operand
    assign w_iin_p0    = iin;
    assign w_result_p0 = mode ? ~w_iin_p0 : sat_negate(w_iin_p0);
    assign w_ovf_p0    = negate_ovf(w_iin_p0, mode);

    // Stage p1: result registers; flags derive from the value being registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_p1  <= '0;
            r_vld_p1  <= 1'b0;
            r_ovf_p1  <= 1'b0;
            r_zero_p1 <= 1'b1;
        end else begin
            r_vld_p1 <= enable;
            if (enable) begin
                r_out_p1  <= w_result_p0;
                r_ovf_p1  <= w_ovf_p0;
                r_zero_p1 <= (w_result_p0 == '0);
            end
        end
    end

    assign out       = r_out_p1;
    assign out_valid = r_vld_p1;
    assign ovf       = r_ovf_p1;
    assign zero      = r_zero_p1;

endmodule

// File: tb/tb_complement.sv
// Scoreboard bench for complement: driver pushes per-cycle expectations, monitor pops and compares.
module tb_complement;

    localparam int W   = 16;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] iin = '0;
    logic [W-1:0] out;
    logic         out_valid;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    complement #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iin       (iin),
        .enable    (enable),
        .mode      (mode),
        .out       (out),
        .out_valid (out_valid),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic         vld;
        logic [W-1:0] o;
        logic         ov;
        logic         z;
        string        tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: what the outputs should show after the most recent edge
    int m_out  = 0;
    bit m_ovf  = 1'b0;
    bit m_zero = 1'b1;

    task automatic drive(input bit r, input bit e, input bit md, input int v, input string tag);
        exp_t x;
        int   a;
        a      = v % MOD;
        rst_n  = r;
        enable = e;
        mode   = md;
        iin    = a[W-1:0];
        @(posedge clk);
        #1;
        if (!r) begin
            m_out  = 0;
            m_ovf  = 1'b0;
            m_zero = 1'b1;
            x.vld  = 1'b0;
        end else begin
            x.vld = e;
            if (e) begin
                if (md) begin
                    m_out = MOD - 1 - a;
                    m_ovf = 1'b0;
                end else begin
                    m_out = (MOD - a) % MOD;
                    m_ovf = (a == MOD / 2);
`ifdef COMPLEMENT_SATURATE_EN
                    if (a == MOD / 2) m_out = MOD / 2 - 1;
`endif
                end
                m_zero = (m_out == 0);
            end
        end
        x.o   = m_out[W-1:0];
        x.ov  = m_ovf;
        x.z   = m_zero;
        x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk({x.tag, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, x.vld});
                chk({x.tag, ".out"},       out,                        x.o);
                chk({x.tag, ".ovf"},       {{(W-1){1'b0}}, ovf},       {{(W-1){1'b0}}, x.ov});
                chk({x.tag, ".zero"},      {{(W-1){1'b0}}, zero},      {{(W-1){1'b0}}, x.z});
            end
        end
    end

    initial begin : stim
        int v;
        int sel;
        drive(0, 1, 0, 'h0005, "reset0");
        drive(0, 0, 0, 'h0000, "reset1");
        drive(1, 1, 0, 'h0001, "neg_one");
        drive(1, 1, 0, 'h0003, "b2b_a");
        drive(1, 1, 0, 'hFFFE, "b2b_b");
        drive(1, 1, 0, 'h8000, "most_neg");
        drive(1, 1, 0, 'h0000, "neg_zero");
        drive(1, 1, 1, 'h00FF, "inv_ff");
        drive(1, 1, 1, 'h8000, "inv_min");
        drive(1, 1, 1, 'hFFFF, "inv_zero");
        drive(1, 1, 0, 'hEDCC, "set_1234");
        drive(1, 0, 0, 'h1111, "hold0");
        drive(1, 0, 1, 'h2222, "hold1");
        drive(1, 0, 0, 'h8000, "hold2");
        drive(1, 1, 0, 'h7FFF, "most_pos");
        drive(1, 1, 0, 'h0009, "stream");
        drive(0, 1, 0, 'h0005, "rst_mid");
        drive(1, 1, 0, 'h0007, "post_rst");
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       v = 0;
                1:       v = MOD / 2;
                2:       v = MOD / 2 - 1;
                3:       v = MOD - 1;
                default: v = $urandom_range(0, MOD - 1);
            endcase
            drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 1) != 0, v, "rand");
        end
        drive(1, 0, 0, 'h0000, "drain");
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/complement.md
COMPLEMENT -- requirements
Module: complement

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits (legal range 2..64).
REQ-002 Port clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port iin  input  WIDTH  operand, two's-complement signed.
REQ-005 Port enable  input  1  operation request; high = complement iin this cycle.
REQ-006 Port mode  input  1  0 = two's complement (negate), 1 = one's complement (bitwise invert).
REQ-007 Port out  output  WIDTH  registered result.
REQ-008 Port out_valid  output  1  high for exactly one cycle per accepted enable.
REQ-009 Port ovf  output  1  registered overflow flag for the current out.
REQ-010 Port zero  output  1  registered flag, high when out equals 0.

Function
REQ-011 When enable=1 at a rising edge, the block SHALL capture the result; out, out_valid, ovf and zero SHALL update at that edge (latency 1 cycle, throughput 1 per cycle).
REQ-012 mode=0: out SHALL be (~iin + 1) truncated to WIDTH bits; carry-out discarded.
REQ-013 mode=1: out SHALL be ~iin; ovf SHALL be 0.
REQ-014 mode=0 with iin = most-negative value (1 followed by WIDTH-1 zeros): ovf SHALL be 1; out per REQ-031; all other inputs give ovf=0.
REQ-015 iin=0, mode=0: out SHALL be 0, zero=1, ovf=0.
REQ-016 zero SHALL reflect the newly registered out value, not iin.
REQ-017 When enable=0 at a rising edge: out, ovf and zero SHALL hold their previous values; out_valid SHALL be 0.
REQ-018 out_valid SHALL be 1 in the cycle after each edge with enable=1, including back-to-back enables (continuously high).
REQ-019 No input is registered other than through the result path; iin and mode are sampled only at edges where enable=1.
REQ-020 No combinational path from any input to any output.

Reset
REQ-021 When rst_n=0 at a rising edge: out=0, out_valid=0, ovf=0, zero=1, regardless of enable.
REQ-022 Reset SHALL take priority over enable in the same cycle; an operation requested during reset is dropped.
REQ-023 The first edge with rst_n=1 and enable=1 SHALL produce a normal result the following cycle.
REQ-024 Outputs SHALL be undefined before the first reset edge; no asynchronous behaviour.

Configuration
REQ-031 Macro COMPLEMENT_SATURATE_EN: when defined, mode=0 on the most-negative input SHALL yield the most-positive value (0 followed by WIDTH-1 ones, 0x7FFF at WIDTH=16) with ovf=1.
REQ-032 When COMPLEMENT_SATURATE_EN is undefined, that case SHALL wrap: out equals iin (0x8000 at WIDTH=16), ovf=1.
REQ-033 The macro SHALL affect no other input value, mode or flag.

Verification
REQ-041 Reset, then enable=1, mode=0, iin=0x0001 -> next cycle out=0xFFFF, out_valid=1, ovf=0, zero=0.
REQ-042 Back-to-back enable=1, mode=0: iin=0x0003 then 0xFFFE -> out=0xFFFD then 0x0002 on consecutive cycles; out_valid held at 1.
REQ-043 mode=0, iin=0x8000 -> out=0x8000, ovf=1 without macro; out=0x7FFF, ovf=1 with COMPLEMENT_SATURATE_EN.
REQ-044 mode=0, iin=0x0000 -> out=0x0000, zero=1; mode=1, iin=0x00FF -> out=0xFF00, ovf=0.
REQ-045 Result 0x1234 registered, then enable=0 for 3 cycles with iin changing -> out stays 0x1234, out_valid=0.
REQ-046 rst_n=0 asserted together with enable=1 mid-stream -> next cycle out=0, out_valid=0, ovf=0, zero=1.
